// File: rtl/alu_dispatch.sv
// Decode/dispatch stage feeding the ALU operand interface: register file, scoreboard,
// hazard stall with writeback forwarding, and a registered one-deep issue bundle.
module alu_dispatch (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_is_imm,
    output logic [4:0]  out_funct,
    output logic [31:0] out_val1,
    output logic [31:0] out_val2,
    output logic [4:0]  out_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        illegal
);

    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic [2:0]  sub;

    assign op  = in_instr[31:26];
    assign rd  = in_instr[25:21];
    assign rs1 = in_instr[20:16];
    assign rs2 = in_instr[15:11];
    assign imm = in_instr[15:0];
    assign sub = in_instr[2:0];

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic [31:0] pending_q, pending_d;
    logic        out_valid_q, out_valid_d;
    logic        out_is_imm_q, out_is_imm_d;
    logic [4:0]  out_funct_q, out_funct_d;
    logic [31:0] out_val1_q, out_val1_d;
    logic [31:0] out_val2_q, out_val2_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        illegal_q, illegal_d;

    logic        is_r, is_i, legal;
    logic        rs1_busy, rs2_busy, rd_busy, hazard;
    logic        accept, legal_accept;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  funct;
    logic [31:0] val2;

    // A pending register stops blocking in the very cycle its writeback arrives.
    always_comb begin
        is_r     = (op == 6'd0);
        is_i     = (op >= 6'd1) && (op <= 6'd5);
        legal    = is_r || is_i;
        rs1_busy = pending_q[rs1] && !(wb_valid && (wb_rd == rs1));
        rs2_busy = pending_q[rs2] && !(wb_valid && (wb_rd == rs2));
        rd_busy  = (rd != 5'd0) && pending_q[rd] && !(wb_valid && (wb_rd == rd));
        hazard   = legal && (rs1_busy || (is_r && rs2_busy) || rd_busy);
        in_ready = rstn && (!out_valid_q || out_ready) && !hazard;
        accept       = in_valid && in_ready;
        legal_accept = accept && legal;
    end

    always_comb begin
        if (rs1 == 5'd0)
            rs1_val = 32'd0;
        else if (wb_valid && (wb_rd == rs1))
            rs1_val = wb_data;
        else
            rs1_val = rf_q[rs1];
        if (rs2 == 5'd0)
            rs2_val = 32'd0;
        else if (wb_valid && (wb_rd == rs2))
            rs2_val = wb_data;
        else
            rs2_val = rf_q[rs2];
    end

    always_comb begin
        funct = 5'd1 << (op[2:0] - 3'd1);
        if (is_r) begin
            case (sub)
                3'd0:    funct = 5'b00001;
                3'd1:    funct = 5'b00000;
                3'd2:    funct = 5'b01001;
                3'd3:    funct = 5'b01010;
                3'd4:    funct = 5'b01100;
                3'd5:    funct = 5'b10001;
                3'd6:    funct = 5'b10010;
                default: funct = 5'b10100;
            endcase
        end
        if (is_r)
            val2 = rs2_val;
        else if (op <= 6'd2)
            val2 = {{16{imm[15]}}, imm};
        else
            val2 = {27'd0, imm[4:0]};
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_is_imm_d = out_is_imm_q;
        out_funct_d  = out_funct_q;
        out_val1_d   = out_val1_q;
        out_val2_d   = out_val2_q;
        out_rd_d     = out_rd_q;
        if (legal_accept) begin
            out_valid_d  = 1'b1;
            out_is_imm_d = is_i;
            out_funct_d  = funct;
            out_val1_d   = rs1_val;
            out_val2_d   = val2;
            out_rd_d     = rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        illegal_d = accept && !legal;
    end

    // Clear before set so a same-cycle dispatch to the written register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid)
            pending_d[wb_rd] = 1'b0;
        if (legal_accept && (rd != 5'd0))
            pending_d[rd] = 1'b1;
        pending_d[0] = 1'b0;
        rf_d = rf_q;
        if (wb_valid && (wb_rd != 5'd0))
            rf_d[wb_rd] = wb_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'd0;
            pending_q    <= 32'd0;
            out_valid_q  <= 1'b0;
            out_is_imm_q <= 1'b0;
            out_funct_q  <= 5'd0;
            out_val1_q   <= 32'd0;
            out_val2_q   <= 32'd0;
            out_rd_q     <= 5'd0;
            illegal_q    <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            pending_q    <= pending_d;
            out_valid_q  <= out_valid_d;
            out_is_imm_q <= out_is_imm_d;
            out_funct_q  <= out_funct_d;
            out_val1_q   <= out_val1_d;
            out_val2_q   <= out_val2_d;
            out_rd_q     <= out_rd_d;
            illegal_q    <= illegal_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_is_imm = out_is_imm_q;
    assign out_funct  = out_funct_q;
    assign out_val1   = out_val1_q;
    assign out_val2   = out_val2_q;
    assign out_rd     = out_rd_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Testbench for alu_dispatch: directed scenarios plus randomized traffic
// compared against a behavioural model of register file, scoreboard and bundle.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_imm;
    logic [4:0]  out_funct;
    logic [31:0] out_val1;
    logic [31:0] out_val2;
    logic [4:0]  out_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_dispatch dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_imm(out_is_imm),
        .out_funct(out_funct), .out_val1(out_val1), .out_val2(out_val2), .out_rd(out_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_rf [32];
    logic        m_pend [32];
    logic        e_valid, e_is_imm, e_illegal, e_in_ready;
    logic [4:0]  e_funct, e_rd;
    logic [31:0] e_val1, e_val2;
    logic [4:0]  r_funct_tab [8] = '{5'b00001, 5'b00000, 5'b01001, 5'b01010,
                                     5'b01100, 5'b10001, 5'b10010, 5'b10100};

    function automatic logic [31:0] r_instr(input logic [2:0] sub, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2);
        return {6'd0, rd, rs1, rs2, 8'd0, sub};
    endfunction

    function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_valid && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic logic m_blocked(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r] && !(wb_valid && wb_rd == r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        e_valid = 0; e_is_imm = 0; e_illegal = 0; e_funct = 0; e_rd = 0; e_val1 = 0; e_val2 = 0;
    endtask

    task automatic set_inputs(input logic v, input logic [31:0] ins, input logic ordy,
                              input logic wbv, input logic [4:0] wbr, input logic [31:0] wbd);
        logic [5:0] op;
        logic       hz;
        in_valid = v; in_instr = ins; out_ready = ordy;
        wb_valid = wbv; wb_rd = wbr; wb_data = wbd;
        #1;
        op = ins[31:26];
        hz = (op <= 6'd5) && (m_blocked(ins[20:16]) || (op == 6'd0 && m_blocked(ins[15:11]))
                              || m_blocked(ins[25:21]));
        e_in_ready = rstn && (!e_valid || ordy) && !hz;
    endtask

    task automatic tick();
        logic [5:0] op;
        logic       acc, legal;
        @(posedge clk);
        op    = in_instr[31:26];
        acc   = in_valid && e_in_ready;
        legal = (op <= 6'd5);
        if (acc && legal) begin
            e_valid  = 1'b1;
            e_rd     = in_instr[25:21];
            e_is_imm = (op != 6'd0);
            e_funct  = (op == 6'd0) ? r_funct_tab[in_instr[2:0]] : 5'd1 << (op - 6'd1);
            e_val1   = m_read(in_instr[20:16]);
            if (op == 6'd0)
                e_val2 = m_read(in_instr[15:11]);
            else if (op <= 6'd2)
                e_val2 = 32'($signed(in_instr[15:0]));
            else
                e_val2 = 32'(in_instr[4:0]);
        end else if (out_ready) begin
            e_valid = 1'b0;
        end
        e_illegal = acc && !legal;
        if (wb_valid) m_pend[wb_rd] = 1'b0;
        if (acc && legal && in_instr[25:21] != 5'd0) m_pend[in_instr[25:21]] = 1'b1;
        if (wb_valid && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rstn = 1'b0;
        set_inputs(1, r_instr(0, 3, 1, 2), 1, 0, 0, 0);
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({out_is_imm, out_funct, out_val1, out_val2, out_rd} !== 75'd0) begin errors++; $display("[TB] FAIL reset_bundle: got %h expected 0", {out_is_imm, out_funct, out_val1, out_val2, out_rd}); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal); end
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        set_inputs(0, 0, 1, 1, 5'd1, 32'd5); tick();
        set_inputs(0, 0, 1, 1, 5'd2, 32'd3); tick();
        set_inputs(1, r_instr(0, 3, 1, 2), 1, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %b expected 1", out_valid); end
        checks++; if (out_funct !== 5'b00001) begin errors++; $display("[TB] FAIL add_funct: got %b expected 00001", out_funct); end
        checks++; if (out_val1 !== 32'd5) begin errors++; $display("[TB] FAIL add_val1: got %h expected 5", out_val1); end
        checks++; if (out_val2 !== 32'd3) begin errors++; $display("[TB] FAIL add_val2: got %h expected 3", out_val2); end
        checks++; if (out_rd !== 5'd3) begin errors++; $display("[TB] FAIL add_rd: got %0d expected 3", out_rd); end
        checks++; if (out_is_imm !== 1'b0) begin errors++; $display("[TB] FAIL add_is_imm: got %b expected 0", out_is_imm); end
    endtask

    task automatic test_imm();
        set_inputs(1, i_instr(6'd1, 4, 1, 16'hFFFF), 1, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL addi_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_is_imm !== 1'b1) begin errors++; $display("[TB] FAIL addi_is_imm: got %b expected 1", out_is_imm); end
        checks++; if (out_funct !== 5'b00001) begin errors++; $display("[TB] FAIL addi_funct: got %b expected 00001", out_funct); end
        checks++; if (out_val2 !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL addi_val2: got %h expected ffffffff", out_val2); end
        checks++; if (out_val1 !== 32'd5) begin errors++; $display("[TB] FAIL addi_val1: got %h expected 5", out_val1); end
        set_inputs(1, i_instr(6'd3, 6, 2, 16'h0123), 1, 0, 0, 0);
        tick();
        checks++; if (out_funct !== 5'b00100) begin errors++; $display("[TB] FAIL slli_funct: got %b expected 00100", out_funct); end
        checks++; if (out_val2 !== 32'd3) begin errors++; $display("[TB] FAIL slli_val2: got %h expected 3", out_val2); end
        set_inputs(0, 0, 1, 1, 5'd3, 32'h33); tick();
        set_inputs(0, 0, 1, 1, 5'd4, 32'h44); tick();
        set_inputs(0, 0, 1, 1, 5'd6, 32'h66); tick();
    endtask

    task automatic test_hazard_forward();
        set_inputs(1, r_instr(0, 5, 1, 2), 1, 0, 0, 0); tick();
        for (int k = 0; k < 2; k++) begin
            set_inputs(1, r_instr(1, 7, 5, 0), 1, 0, 0, 0);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hazard_stall %0d: got %b expected 0", k, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hazard_bubble %0d: got %b expected 0", k, out_valid); end
        end
        set_inputs(1, r_instr(1, 7, 5, 0), 1, 1, 5'd5, 32'h10);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL wb_release: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_val1 !== 32'h10) begin errors++; $display("[TB] FAIL fwd_val1: got %h expected 10", out_val1); end
        checks++; if (out_funct !== 5'b00000) begin errors++; $display("[TB] FAIL sub_funct: got %b expected 00000", out_funct); end
        checks++; if (out_rd !== 5'd7) begin errors++; $display("[TB] FAIL sub_rd: got %0d expected 7", out_rd); end
        set_inputs(0, 0, 1, 1, 5'd7, 32'h77); tick();
    endtask

    task automatic test_backpressure();
        set_inputs(1, r_instr(0, 8, 1, 2), 1, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            set_inputs(1, r_instr(0, 9, 1, 2), 0, 0, 0, 0);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready %0d: got %b expected 0", k, in_ready); end
            tick();
            checks++; if ({out_valid, out_rd, out_val1, out_val2} !== {1'b1, 5'd8, 32'd5, 32'd3}) begin errors++; $display("[TB] FAIL hold_bundle %0d: got %h expected %h", k, {out_valid, out_rd, out_val1, out_val2}, {1'b1, 5'd8, 32'd5, 32'd3}); end
        end
        set_inputs(1, r_instr(0, 9, 1, 2), 1, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_rd !== 5'd9) begin errors++; $display("[TB] FAIL release_rd: got %0d expected 9", out_rd); end
        set_inputs(0, 0, 1, 1, 5'd8, 32'h88); tick();
        set_inputs(0, 0, 1, 1, 5'd9, 32'h99); tick();
    endtask

    task automatic test_illegal();
        set_inputs(1, {6'h3F, 5'd10, 21'd0}, 1, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse: got %b expected 1", illegal); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_no_bundle: got %b expected 0", out_valid); end
        set_inputs(1, r_instr(0, 10, 1, 2), 1, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_no_pend: got %b expected 1", in_ready); end
        tick();
        checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_one_cycle: got %b expected 0", illegal); end
        set_inputs(1, r_instr(7, 11, 0, 2), 1, 0, 0, 0); tick();
        checks++; if (out_funct !== 5'b10100) begin errors++; $display("[TB] FAIL fneg_funct: got %b expected 10100", out_funct); end
        checks++; if (out_val2 !== 32'd3) begin errors++; $display("[TB] FAIL fneg_val2: got %h expected 3", out_val2); end
        set_inputs(0, 0, 1, 1, 5'd10, 32'h1010); tick();
        set_inputs(0, 0, 1, 1, 5'd11, 32'h1111); tick();
    endtask

    task automatic test_reset_mid();
        set_inputs(1, r_instr(0, 5, 1, 2), 0, 0, 0, 0); tick();
        set_inputs(0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        #1;
        model_reset();
        checks++; if ({out_valid, out_is_imm, out_funct, out_val1, out_val2, out_rd} !== 76'd0) begin errors++; $display("[TB] FAIL midreset_outputs: got %h expected 0", {out_valid, out_is_imm, out_funct, out_val1, out_val2, out_rd}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        set_inputs(1, r_instr(1, 12, 5, 0), 1, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL postreset_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if ({out_valid, out_val1} !== {1'b1, 32'd0}) begin errors++; $display("[TB] FAIL postreset_val1: got %h expected %h", {out_valid, out_val1}, {1'b1, 32'd0}); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [5:0]  op;
        int          p;
        for (int i = 0; i < 400; i++) begin
            p = $urandom_range(0, 9);
            op = (p < 5) ? 6'd0 : (p < 9) ? 6'($urandom_range(1, 5)) : 6'($urandom_range(6, 63));
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            ins[15:11] = 5'($urandom_range(0, 7));
            set_inputs(($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 4) < 2), 5'($urandom_range(0, 7)), $urandom);
            checks++; if (in_ready !== e_in_ready) begin errors++; $display("[TB] FAIL rand_in_ready %0d: got %b expected %b", i, in_ready, e_in_ready); end
            tick();
            checks++; if (out_valid !== e_valid) begin errors++; $display("[TB] FAIL rand_valid %0d: got %b expected %b", i, out_valid, e_valid); end
            checks++; if (illegal !== e_illegal) begin errors++; $display("[TB] FAIL rand_illegal %0d: got %b expected %b", i, illegal, e_illegal); end
            if (e_valid) begin
                checks++;
                if ({out_is_imm, out_funct, out_val1, out_val2, out_rd} !== {e_is_imm, e_funct, e_val1, e_val2, e_rd}) begin
                    errors++;
                    $display("[TB] FAIL rand_bundle %0d: got %h expected %h", i, {out_is_imm, out_funct, out_val1, out_val2, out_rd}, {e_is_imm, e_funct, e_val1, e_val2, e_rd});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_hazard_forward();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
